// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary definitions: control bit indices, per-boundary widths,
// packed data layouts with their field offsets, and the zero-control constant.
package pipe_pkg;

  // Control bundle bit positions, common to every boundary.
  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMREAD  = 1;
  localparam int unsigned CTRL_MEMWRITE = 2;
  localparam int unsigned CTRL_MEMTOREG = 3;
  localparam int unsigned CTRL_BRANCH   = 4;
  localparam int unsigned CTRL_JUMP     = 5;

  localparam int unsigned CTRL_W        = 6;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned REG_W         = 5;

  localparam logic [CTRL_W-1:0] CTRL_ZERO = '0;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] imm;
    logic [WORD_W-1:0] npc1;
    logic [WORD_W-1:0] pc;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
  } idex_data_t;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] result;
    logic              zero;
    logic [WORD_W-1:0] next_pc_branch;
    logic [WORD_W-1:0] npc1;
    logic [WORD_W-1:0] pc;
    logic [REG_W-1:0]  write_reg;
  } exmem_data_t;

  typedef struct packed {
    logic [WORD_W-1:0] read_data;
    logic [WORD_W-1:0] result;
    logic [WORD_W-1:0] npc1;
    logic [REG_W-1:0]  write_reg;
  } memwb_data_t;

  localparam int unsigned IDEX_CTRL_W  = CTRL_W;
  localparam int unsigned IDEX_DATA_W  = $bits(idex_data_t);
  localparam int unsigned EXMEM_CTRL_W = CTRL_W;
  localparam int unsigned EXMEM_DATA_W = $bits(exmem_data_t);
  localparam int unsigned MEMWB_CTRL_W = CTRL_W;
  localparam int unsigned MEMWB_DATA_W = $bits(memwb_data_t);

  // EX/MEM field LSB offsets inside the flat data bundle.
  localparam int unsigned EXMEM_OFF_WRITEREG = 0;
  localparam int unsigned EXMEM_OFF_PC       = EXMEM_OFF_WRITEREG + REG_W;
  localparam int unsigned EXMEM_OFF_NPC1     = EXMEM_OFF_PC + WORD_W;
  localparam int unsigned EXMEM_OFF_NEXTPC   = EXMEM_OFF_NPC1 + WORD_W;
  localparam int unsigned EXMEM_OFF_ZERO     = EXMEM_OFF_NEXTPC + WORD_W;
  localparam int unsigned EXMEM_OFF_RESULT   = EXMEM_OFF_ZERO + 1;
  localparam int unsigned EXMEM_OFF_B        = EXMEM_OFF_RESULT + WORD_W;
  localparam int unsigned EXMEM_OFF_INSTR    = EXMEM_OFF_B + WORD_W;

  // MEM/WB field LSB offsets inside the flat data bundle.
  localparam int unsigned MEMWB_OFF_WRITEREG = 0;
  localparam int unsigned MEMWB_OFF_NPC1     = MEMWB_OFF_WRITEREG + REG_W;
  localparam int unsigned MEMWB_OFF_RESULT   = MEMWB_OFF_NPC1 + WORD_W;
  localparam int unsigned MEMWB_OFF_READDATA = MEMWB_OFF_RESULT + WORD_W;

  // True when a control bundle would change architectural state.
  function automatic logic ctrl_writes(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_REGWRITE] | ctrl[CTRL_MEMWRITE];
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag plus control and data payload, with load and clear.
// Clear wins over load; a cleared entry always shows zero control.
module pipe_slot #(
  parameter int unsigned CTRL_W     = 6,
  parameter int unsigned DATA_W     = 198,
  parameter bit          CLEAR_DATA = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (CLEAR_DATA) data_d = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with stall and flush; bubbles carry zero control.
// Define PIPE_STAGE_SKID_EN to add a skid entry so in_ready no longer depends on out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W               = EXMEM_CTRL_W,
  parameter int unsigned DATA_W               = EXMEM_DATA_W,
  parameter bit          CLEAR_DATA_ON_BUBBLE = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  logic              in_fire;
  logic              out_fire;
  logic              out_load;
  logic              out_clear;
  logic [CTRL_W-1:0] out_ctrl_d;
  logic [DATA_W-1:0] out_data_d;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & enable;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic              skid_load;
  logic              skid_clear;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign in_ready = enable & ~flush & ~skid_valid;

  // Output takes the skid first; new input goes to the skid only under backpressure.
  always_comb begin
    out_load   = 1'b0;
    out_clear  = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    out_ctrl_d = in_ctrl;
    out_data_d = in_data;
    if (flush) begin
      out_clear  = 1'b1;
      skid_clear = 1'b1;
    end else if (enable) begin
      if (skid_valid) begin
        if (out_fire) begin
          out_load   = 1'b1;
          out_ctrl_d = skid_ctrl;
          out_data_d = skid_data;
          skid_clear = 1'b1;
        end
      end else if (in_fire) begin
        if (~out_valid | out_fire) out_load  = 1'b1;
        else                       skid_load = 1'b1;
      end else if (out_fire) begin
        out_clear = 1'b1;
      end
    end
  end

  pipe_slot #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .CLEAR_DATA (CLEAR_DATA_ON_BUBBLE)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .ctrl_i  (in_ctrl),
    .data_i  (in_data),
    .valid_o (skid_valid),
    .ctrl_o  (skid_ctrl),
    .data_o  (skid_data)
  );
`else
  assign in_ready   = enable & ~flush & (~out_valid | out_ready);
  assign out_ctrl_d = in_ctrl;
  assign out_data_d = in_data;
  assign out_load   = in_fire;
  // A drain without a replacement leaves a bubble behind.
  assign out_clear  = flush | (out_fire & ~in_fire);
`endif

  pipe_slot #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .CLEAR_DATA (CLEAR_DATA_ON_BUBBLE)
  ) u_out (
    .clock   (clock),
    .reset   (reset),
    .load_i  (out_load),
    .clear_i (out_clear),
    .ctrl_i  (out_ctrl_d),
    .data_i  (out_data_d),
    .valid_o (out_valid),
    .ctrl_o  (out_ctrl),
    .data_o  (out_data)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table, hand-written corner sequences, and a
// randomized run against a FIFO reference model (depth 1, or 2 with PIPE_STAGE_SKID_EN).
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned CW  = EXMEM_CTRL_W;
  localparam int unsigned DW  = EXMEM_DATA_W;
  localparam bit          CLR = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit          SKID = 1'b1;
`else
  localparam bit          SKID = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, enable, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  pipe_stage_reg #(
    .CTRL_W               (CW),
    .DATA_W               (DW),
    .CLEAR_DATA_ON_BUBBLE (CLR)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
  );

  typedef struct {
    logic          rst, en, fl, iv, ordy;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    logic          chk_rdy, exp_rdy, exp_v;
    logic [CW-1:0] exp_ctrl;
    logic [DW-1:0] exp_data;
  } vec_t;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } pl_t;

  vec_t tbl[$];
  pl_t  mq[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic cyc(input logic rst, en, fl, iv, ordy,
                     input logic [CW-1:0] c, input logic [DW-1:0] d);
    @(negedge clock);
    reset = rst; enable = en; flush = fl; in_valid = iv; out_ready = ordy;
    in_ctrl = c; in_data = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [CW-1:0] c,
                         input logic [DW-1:0] d);
    chk({nm, "_valid"}, DW'(out_valid), DW'(v));
    chk({nm, "_ctrl"},  DW'(out_ctrl),  DW'(c));
    chk({nm, "_data"},  out_data,       d);
  endtask

  function automatic vec_t mk(input logic rst, en, fl, iv, ordy,
                              input logic [CW-1:0] c, input logic [DW-1:0] d,
                              input logic chkr, exr, exv,
                              input logic [CW-1:0] ec, input logic [DW-1:0] ed);
    vec_t v;
    v.rst = rst; v.en = en; v.fl = fl; v.iv = iv; v.ordy = ordy;
    v.ctrl = c; v.data = d;
    v.chk_rdy = chkr; v.exp_rdy = exr; v.exp_v = exv;
    v.exp_ctrl = ec; v.exp_data = ed;
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r = '0;
    for (int k = 0; k < 7; k++) r = {r[DW-33:0], 32'($urandom)};
    return r;
  endfunction

  function automatic logic [DW-1:0] held(input logic [DW-1:0] d);
    return CLR ? '0 : d;
  endfunction

  initial begin
    logic          rst, en, fl, iv, ordy, exp_rdy, exp_v;
    logic [CW-1:0] c, exp_c;
    logic [DW-1:0] d, exp_d, mhold;

    reset = 1'b1; enable = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;

    //          rst en fl iv or ctrl   data        chkr rdy v  ectrl  edata
    tbl.push_back(mk(1, 1, 0, 1, 1, 6'h3F, DW'(32'h77), 0, 0, 0, 6'h00, DW'(0)));
    tbl.push_back(mk(1, 1, 0, 1, 1, 6'h3F, DW'(32'h77), 1, 1, 0, 6'h00, DW'(0)));
    tbl.push_back(mk(0, 1, 0, 1, 1, 6'h01, DW'(1),      1, 1, 1, 6'h01, DW'(1)));
    tbl.push_back(mk(0, 1, 0, 1, 1, 6'h02, DW'(2),      1, 1, 1, 6'h02, DW'(2)));
    tbl.push_back(mk(0, 1, 0, 1, 1, 6'h03, DW'(3),      1, 1, 1, 6'h03, DW'(3)));
    tbl.push_back(mk(0, 1, 0, 1, 1, 6'h04, DW'(4),      1, 1, 1, 6'h04, DW'(4)));
    tbl.push_back(mk(0, 1, 0, 1, 1, 6'h05, DW'(5),      1, 1, 1, 6'h05, DW'(5)));
    tbl.push_back(mk(0, 1, 1, 1, 1, 6'h3F, DW'(32'h99), 1, 0, 0, 6'h00, held(DW'(5))));
    tbl.push_back(mk(0, 1, 0, 0, 1, 6'h3F, DW'(32'h98), 1, 1, 0, 6'h00, held(DW'(5))));
    tbl.push_back(mk(0, 1, 0, 1, 1, 6'h0A, DW'(32'hA),  1, 1, 1, 6'h0A, DW'(32'hA)));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 0, 0, 1, 1, 6'h3F, DW'(32'hBB), 1, 0, 1, 6'h0A, DW'(32'hA)));
    tbl.push_back(mk(0, 1, 0, 1, 1, 6'h0B, DW'(32'hB),  1, 1, 1, 6'h0B, DW'(32'hB)));
    tbl.push_back(mk(0, 1, 0, 0, 1, 6'h00, DW'(0),      1, 1, 0, 6'h00, held(DW'(32'hB))));
    tbl.push_back(mk(0, 1, 0, 1, 0, 6'h0C, DW'(32'hC),  1, 1, 1, 6'h0C, DW'(32'hC)));
    tbl.push_back(mk(0, 0, 1, 1, 1, 6'h3F, DW'(32'hCC), 1, 0, 0, 6'h00, held(DW'(32'hC))));
    tbl.push_back(mk(0, 1, 0, 1, 0, 6'h0D, DW'(32'hD),  1, 1, 1, 6'h0D, DW'(32'hD)));
    tbl.push_back(mk(1, 0, 1, 1, 1, 6'h3F, DW'(32'hDD), 1, 0, 0, 6'h00, DW'(0)));

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].en, tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].ctrl, tbl[i].data);
      if (tbl[i].chk_rdy) chk($sformatf("tbl%0d_rdy", i), DW'(in_ready), DW'(tbl[i].exp_rdy));
      tick();
      chk_out($sformatf("tbl%0d", i), tbl[i].exp_v, tbl[i].exp_ctrl, tbl[i].exp_data);
    end

    // Backpressure: A5A5 held while 5A5A waits (or sits in the skid entry).
    cyc(0, 1, 0, 1, 0, 6'h01, DW'(32'hA5A5));
    chk("bp_load_rdy", DW'(in_ready), DW'(1));
    tick();
    chk_out("bp_load", 1'b1, 6'h01, DW'(32'hA5A5));
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 1, 0, 6'h02, DW'(32'h5A5A));
      chk($sformatf("bp_stall%0d_rdy", k), DW'(in_ready), DW'(SKID && k == 0));
      tick();
      chk_out($sformatf("bp_stall%0d", k), 1'b1, 6'h01, DW'(32'hA5A5));
    end
    cyc(0, 1, 0, 1, 1, 6'h02, DW'(32'h5A5A));
    chk("bp_release_rdy", DW'(in_ready), DW'(!SKID));
    tick();
    chk_out("bp_release", 1'b1, 6'h02, DW'(32'h5A5A));
    cyc(0, 1, 0, 0, 1, 6'h00, DW'(0));
    chk("bp_drain_rdy", DW'(in_ready), DW'(1));
    tick();
    chk_out("bp_drain", 1'b0, 6'h00, held(DW'(32'h5A5A)));

    // Reset with the stage (and skid, if present) full.
    cyc(0, 1, 0, 1, 0, 6'h03, DW'(32'h111));
    tick();
    cyc(0, 1, 0, 1, 0, 6'h04, DW'(32'h222));
    tick();
    chk_out("full", 1'b1, 6'h03, DW'(32'h111));
    cyc(1, 1, 0, 1, 0, 6'h05, DW'(32'h333));
    tick();
    chk_out("midrst", 1'b0, 6'h00, DW'(0));
    cyc(0, 1, 0, 0, 0, 6'h00, DW'(0));
    chk("midrst_rdy", DW'(in_ready), DW'(1));
    tick();
    chk_out("midrst_idle", 1'b0, 6'h00, DW'(0));
    cyc(0, 1, 0, 1, 1, 6'h06, DW'(32'h444));
    tick();
    chk_out("midrst_first", 1'b1, 6'h06, DW'(32'h444));

    // Randomized run against the FIFO model.
    cyc(1, 1, 0, 0, 0, 6'h00, DW'(0));
    tick();
    mq.delete();
    mhold = '0;
    for (int i = 0; i < 500; i++) begin
      rst  = ($urandom_range(0, 59) == 0);
      en   = ($urandom_range(0, 7) != 0);
      fl   = ($urandom_range(0, 24) == 0);
      iv   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 2) != 0);
      c    = CW'($urandom);
      d    = rand_data();
      cyc(rst, en, fl, iv, ordy, c, d);
      exp_rdy = en & ~fl & (SKID ? (mq.size() < 2) : (mq.size() == 0 || ordy));
      chk("rnd_rdy", DW'(in_ready), DW'(exp_rdy));
      tick();
      if (rst) begin
        mq.delete();
        mhold = '0;
      end else if (fl) begin
        mq.delete();
      end else if (en) begin
        if (mq.size() > 0 && ordy) void'(mq.pop_front());
        if (iv && exp_rdy) mq.push_back('{c: c, d: d});
      end
      if (mq.size() > 0) mhold = mq[0].d;
      else if (CLR) mhold = '0;
      exp_v = (mq.size() > 0);
      exp_c = exp_v ? mq[0].c : '0;
      exp_d = exp_v ? mq[0].d : mhold;
      chk_out("rnd", exp_v, exp_c, exp_d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register. Successor to the fixed-field stage registers (ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle between stages, using:
  - a valid/ready handshake;
  - a global enable (stall);
  - a per-stage flush that inserts a bubble.
- A bubble always presents zeroed control bits, so downstream never sees spurious RegWrite/MemWrite.
- Instantiated once per pipeline boundary, with widths set from the shared package.

Parameters:
- CTRL_W, 6, control bundle width (RegWrite, MemRead, MemWrite, MemToReg, Branch, Jump for EX/MEM).
- DATA_W, 198, packed data bundle width (EX/MEM: Instr, B, Result, Zero, nextPCBranch, NPC1, PC, writeReg).
- CLEAR_DATA_ON_BUBBLE, 0, when 1, data is zeroed on reset, flush and drain; when 0, data is retained.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  global stage enable; 0 freezes all state
- flush  in  1  discard stage contents and block input this cycle
- in_valid  in  1  upstream has a payload
- in_ready  out  1  stage accepts payload this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  stage holds a valid payload
- out_ready  in  1  downstream consumes payload
- out_ctrl  out  CTRL_W  registered control; all-zero whenever out_valid=0
- out_data  out  DATA_W  registered data

Behaviour:
- Reset (clock edge with reset=1) sets:
  - out_valid=0, out_ctrl=0, out_data=0;
  - skid entry (if present) invalid and zero.
- Reset overrides flush and enable.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready & enable.
  - Downstream must qualify consumption with the same enable.
- Base variant (single entry):
  - in_ready = enable & ~flush & (~out_valid | out_ready). Combinational.
  - Priority per edge: reset > flush > ~enable > in_fire > out_fire.
- Flush:
  - Sets out_valid=0 and out_ctrl=0.
  - out_data is zeroed if CLEAR_DATA_ON_BUBBLE, otherwise held.
  - Any concurrent input is dropped; in_ready is 0 that cycle.
- enable=0: every register holds; in_ready=0; out_valid stays visible unchanged.
- On in_fire: out_valid=1, out_ctrl=in_ctrl, out_data=in_data. Latency is 1 cycle.
- out_fire without in_fire: out_valid=0, out_ctrl=0, data per CLEAR_DATA_ON_BUBBLE.
- out_fire with in_fire in the same cycle: replace with the new payload. Full throughput, no bubble.
- in_valid=0 while the stage is empty: stays empty; out_ctrl stays 0.
- Payloads are never duplicated or reordered.
- Payloads are lost only by flush or reset.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined: a second (skid) entry is added, and in_ready becomes registered.
  - in_ready = enable & ~flush & ~skid_valid.
  - in_ready no longer depends combinationally on out_ready, which breaks the ready timing path.
  - An in_fire while out_valid & ~out_ready loads the skid entry.
  - On out_fire with skid_valid: skid moves to the output on the next edge; skid_valid=0. A concurrent in_fire is impossible because in_ready=0.
  - On out_fire with the skid empty: in_fire loads the output as in the base variant.
  - Flush invalidates both entries and zeroes both ctrl fields.
  - Ordering is strictly FIFO; throughput is 1 per cycle when out_ready=1.
- Undefined: single entry only, exactly the base behaviour; no skid registers are synthesised.

Decomposition:
- Shared package pipe_pkg holds:
  - CTRL_W/DATA_W constants per boundary (IDEX, EXMEM, MEMWB);
  - ctrl bit index constants (CTRL_REGWRITE=0 … CTRL_JUMP=5);
  - data field offset constants for packing/unpacking;
  - the zero-control constant.
- One sub-module is natural: pipe_slot, a single valid+ctrl+data entry with load/clear. It is instantiated once for the output and, under PIPE_STAGE_SKID_EN, once more for the skid entry.

Test Plan:
- Reset: hold reset=1 for 2 cycles while in_valid=1 and in_ctrl=6'h3F → out_valid=0, out_ctrl=0, out_data=0; after release, first in_fire appears 1 cycle later.
- Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles → out_data 1,2,3,4 on consecutive cycles; in_ready constantly 1; no bubbles.
- Backpressure: load data A5A5, then out_ready=0 for 3 cycles with in_valid=1 and data 5A5A →
  - base: in_ready=0; A5A5 held; 5A5A accepted the cycle out_ready returns.
  - skid: 5A5A accepted once into the skid, then in_ready=0; output order A5A5 then 5A5A.
- Flush: stage holds ctrl 6'b000101; assert flush with in_valid=1 → next cycle out_valid=0, out_ctrl=0; input not taken; data zeroed only if CLEAR_DATA_ON_BUBBLE=1.
- Stall: enable=0 for 4 cycles with out_ready=1 and in_valid=1 → out_valid/out_ctrl/out_data unchanged; in_ready=0; nothing consumed; flow resumes when enable=1.
- Reset mid-operation: skid and output both full, assert reset → both cleared in one edge; out_valid=0 and in_ready=1 the cycle after release.
